interrupt_read_controller: RTL

Read-side companion to the OCW3 register block of the 8259A model. It services CPU read cycles. It selects IRR, ISR, IMR, or a poll word according to the OCW3 read settings, the A0 address and a latched poll command. The selected value is captured into a snapshot that stays stable for the whole read. At the end of a poll read it issues a poll acknowledge to the in-service logic. It sits between the bus control logic (read strobe, A0, decoded write strobes) and the interrupt registers, and drives the internal data bus output path.

---
 rtl/interrupt_read_controller_if.sv | 36 +++
 rtl/interrupt_read_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/interrupt_read_controller_if.sv
// rtl/interrupt_read_controller_if.sv - bus/register bundle between 8259A bus control and the read controller
interface interrupt_read_controller_if;
  logic       read_strobe;
  logic       address;
  logic       write_initial_command_word_1;
  logic       write_operation_control_word_3_registers;
  logic [7:0] internal_data_bus;
  logic       enable_read_register;
  logic       read_register_isr_or_irr;
  logic [7:0] interrupt_request_register;
  logic [7:0] in_service_register;
  logic [7:0] interrupt_mask;
  logic [7:0] highest_level_in_request;
  logic [7:0] data_bus_out;
  logic       data_bus_out_enable;
  logic       poll_acknowledge;
  logic [2:0] poll_level;

  modport master (
    output read_strobe, address,
    output write_initial_command_word_1, write_operation_control_word_3_registers,
    output internal_data_bus, enable_read_register, read_register_isr_or_irr,
    output interrupt_request_register, in_service_register, interrupt_mask,
    output highest_level_in_request,
    input  data_bus_out, data_bus_out_enable, poll_acknowledge, poll_level
  );

  modport slave (
    input  read_strobe, address,
    input  write_initial_command_word_1, write_operation_control_word_3_registers,
    input  internal_data_bus, enable_read_register, read_register_isr_or_irr,
    input  interrupt_request_register, in_service_register, interrupt_mask,
    input  highest_level_in_request,
    output data_bus_out, data_bus_out_enable, poll_acknowledge, poll_level
  );
endinterface

// File: rtl/interrupt_read_controller.sv
// rtl/interrupt_read_controller.sv - 8259A read path: IRR/ISR/IMR/poll snapshot and poll acknowledge
module interrupt_read_controller (
  input  logic                        clock,
  input  logic                        reset,
  interrupt_read_controller_if.slave  bus
);

  typedef enum logic {IDLE, READ_ACTIVE} state_t;
  typedef enum logic [2:0] {SRC_NONE, SRC_IRR, SRC_ISR, SRC_IMR, SRC_POLL} source_t;

  state_t     state, state_next;
  source_t    source, source_next;
  logic       poll_pending, poll_pending_next;
  logic       read_strobe_prev;
  logic [7:0] data_q, data_next;
  logic       enable_q, enable_next;
  logic       ack_q, ack_next;
  logic [2:0] level_q, level_next;
  logic [7:0] poll_word;
  logic       read_start;
  logic       unused_data_bits;

  // Only D2 (poll command) matters here; the OCW3 block decodes the rest.
  assign unused_data_bits = ^{bus.internal_data_bus[7:3], bus.internal_data_bus[1:0]};

  // Downward scan so the lowest set index is the one left standing.
  always_comb begin
    poll_word = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (bus.highest_level_in_request[i]) begin
        poll_word = {1'b1, 4'b0000, i[2:0]};
      end
    end
  end

  assign read_start = bus.read_strobe && !read_strobe_prev && (state == IDLE);

  always_comb begin
    state_next        = state;
    source_next       = source;
    poll_pending_next = poll_pending;
    data_next         = data_q;
    enable_next       = enable_q;
    ack_next          = 1'b0;
    level_next        = 3'd0;

    unique case (state)
      IDLE: begin
        if (read_start) begin
          state_next  = READ_ACTIVE;
          enable_next = 1'b1;
          if (poll_pending) begin
            source_next = SRC_POLL;
            data_next   = poll_word;
          end else if (bus.address) begin
            source_next = SRC_IMR;
            data_next   = bus.interrupt_mask;
          end else if (bus.enable_read_register) begin
            source_next = bus.read_register_isr_or_irr ? SRC_ISR : SRC_IRR;
            data_next   = bus.read_register_isr_or_irr ? bus.in_service_register
                                                       : bus.interrupt_request_register;
          end else begin
            source_next = SRC_NONE;
            data_next   = 8'h00;
            enable_next = 1'b0;
          end
        end
      end
      READ_ACTIVE: begin
        if (bus.write_initial_command_word_1) begin
          state_next  = IDLE;
          enable_next = 1'b0;
        end else if (!bus.read_strobe) begin
          state_next  = IDLE;
          enable_next = 1'b0;
          if (source == SRC_POLL) begin
            poll_pending_next = 1'b0;
            ack_next          = data_q[7];
            level_next        = data_q[7] ? data_q[2:0] : 3'd0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A fresh poll command outlives a same-cycle poll completion; ICW1 beats both.
    if (bus.write_operation_control_word_3_registers && bus.internal_data_bus[2]) begin
      poll_pending_next = 1'b1;
    end
    if (bus.write_initial_command_word_1) begin
      poll_pending_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      source           <= SRC_NONE;
      poll_pending     <= 1'b0;
      read_strobe_prev <= 1'b0;
      data_q           <= 8'h00;
      enable_q         <= 1'b0;
      ack_q            <= 1'b0;
      level_q          <= 3'd0;
    end else begin
      state            <= state_next;
      source           <= source_next;
      poll_pending     <= poll_pending_next;
      read_strobe_prev <= bus.read_strobe;
      data_q           <= data_next;
      enable_q         <= enable_next;
      ack_q            <= ack_next;
      level_q          <= level_next;
    end
  end

  assign bus.data_bus_out        = data_q;
  assign bus.data_bus_out_enable = enable_q;
  assign bus.poll_acknowledge    = ack_q;
  assign bus.poll_level          = level_q;

endmodule
